// File: rtl/regfile_pkg.sv
// regfile_pkg: shared address-width helper, zero-register index and write-request type.
package regfile_pkg;
  localparam int width_def_c = 32;
  localparam int depth_def_c = 32;
  localparam int zero_reg_c = 0;
  function automatic int addr_w_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  localparam int addr_w_def_c = addr_w_f(depth_def_c);
  typedef struct packed {
    logic                    en;
    logic [addr_w_def_c-1:0] addr;
    logic [width_def_c-1:0]  data;
  } wr_req_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with flush > issue > write-clear priority.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int depth_p = 32,
  parameter int write_ports_p = 2,
  localparam int addr_w = addr_w_f(depth_p)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [write_ports_p-1:0]        wr_en_i,
  input  logic [write_ports_p*addr_w-1:0] wr_addr_i,
  input  logic                            issue_en_i,
  input  logic [addr_w-1:0]               issue_addr_i,
  input  logic                            flush_i,
  output logic [depth_p-1:0]              busy_vec_o
);
  logic [depth_p-1:0] busy_q, busy_d;
  function automatic logic valid_f(input logic [addr_w-1:0] a);
    return a != addr_w'(zero_reg_c) && {1'b0, a} < (addr_w+1)'(depth_p);
  endfunction
  // later assignments override earlier ones, giving the priority order
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < write_ports_p; w++)
      if (wr_en_i[w] && valid_f(wr_addr_i[w*addr_w +: addr_w])) busy_d[wr_addr_i[w*addr_w +: addr_w]] = 1'b0;
    if (issue_en_i && valid_f(issue_addr_i)) busy_d[issue_addr_i] = 1'b1;
    if (flush_i) busy_d = '0;
    busy_d[zero_reg_c] = 1'b0;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) busy_q <= '0;
    else busy_q <= busy_d;
  assign busy_vec_o = busy_q;
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with scoreboard and optional write-to-read bypass.
module regfile_mp_sb import regfile_pkg::*; #(
  parameter int width_p = 32,
  parameter int depth_p = 32,
  parameter int read_ports_p = 2,
  parameter int write_ports_p = 2,
  parameter int bypass_p = 1,
  localparam int addr_w = addr_w_f(depth_p)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [read_ports_p*addr_w-1:0]   rd_addr_i,
  output logic [read_ports_p*width_p-1:0]  rd_data_o,
  output logic [read_ports_p-1:0]          rd_busy_o,
  input  logic [write_ports_p-1:0]         wr_en_i,
  input  logic [write_ports_p*addr_w-1:0]  wr_addr_i,
  input  logic [write_ports_p*width_p-1:0] wr_data_i,
  input  logic                             issue_en_i,
  input  logic [addr_w-1:0]                issue_addr_i,
  input  logic                             flush_i,
  output logic [depth_p-1:0]               busy_vec_o
);
  logic [width_p-1:0] mem_q [depth_p];
  logic [width_p-1:0] mem_d [depth_p];
  function automatic logic valid_f(input logic [addr_w-1:0] a);
    return a != addr_w'(zero_reg_c) && {1'b0, a} < (addr_w+1)'(depth_p);
  endfunction
  regfile_scoreboard #(.depth_p(depth_p), .write_ports_p(write_ports_p)) u_sb (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .issue_en_i(issue_en_i), .issue_addr_i(issue_addr_i), .flush_i(flush_i),
    .busy_vec_o(busy_vec_o)
  );
  // ascending port order lets the highest-index port win a collision
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < write_ports_p; w++)
      if (wr_en_i[w] && valid_f(wr_addr_i[w*addr_w +: addr_w]))
        mem_d[wr_addr_i[w*addr_w +: addr_w]] = wr_data_i[w*width_p +: width_p];
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  for (genvar p = 0; p < read_ports_p; p++) begin : g_rd
    logic [addr_w-1:0]  a;
    logic [width_p-1:0] d;
    logic               b;
    assign a = rd_addr_i[p*addr_w +: addr_w];
    // bypass is gated by reset so outputs read zero while rst_i is high
    always_comb begin
      d = valid_f(a) ? mem_q[a] : '0;
      b = valid_f(a) && busy_vec_o[a];
      for (int w = 0; w < write_ports_p; w++)
        if (bypass_p != 0 && !rst_i && valid_f(a) && wr_en_i[w] && wr_addr_i[w*addr_w +: addr_w] == a) begin
          d = wr_data_i[w*width_p +: width_p];
          b = 1'b0;
        end
    end
    assign rd_data_o[p*width_p +: width_p] = d;
    assign rd_busy_o[p] = b;
  end
endmodule
